wishbone_slave_mem: RTL and testbench

- Wishbone classic-cycle slave memory model; the downstream consumer of the verification Wishbone master driver's bus (adr/dout/cyc/stb/sel/we in, din/ack/err/rty out).
- Decodes a configurable address window, inserts programmable wait states, performs byte-lane writes/reads on an internal word array and returns exactly one termination per accepted access.
- Lets block-level UART benches run master transactions without the real DUT attached.

---
 rtl/wishbone_slave_pkg.sv | 30 +++
 rtl/wishbone_slave_mem_array.sv | 30 +++
 rtl/wishbone_slave_mem.sv | 176 +++++++++++++++++
 tb/tb_wishbone_slave_mem.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_slave_pkg.sv
// Shared types and constants for the Wishbone classic-cycle slave memory model:
// FSM state encoding, termination codes, wait-state range and a lane-mask helper.
package wishbone_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        TERM_ACK,
        TERM_ERR,
        TERM_RTY
    } term_e;

    localparam int WAIT_STATES_MAX = 15;

    // Expands the four byte-lane selects into a 32-bit data mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wishbone_slave_mem_array.sv
// Word array with per-byte-lane synchronous write and a registered read port.
module wishbone_slave_mem_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [3:0]            sel,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; clearing every word would cost a
    // reset fan-out per bit and the bus contract says contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/wishbone_slave_mem.sv
// Wishbone classic-cycle slave memory: window decode, programmable wait states,
// byte-lane access and one termination per access. Retry option: WB_SLAVE_RETRY_EN.
module wishbone_slave_mem
    import wishbone_slave_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter int          RTY_PERIOD  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        cyc,
    input  logic        stb,
    input  logic [3:0]  sel,
    input  logic        we,
    output logic        ack,
    output logic        err,
    output logic        rty,
    output logic [15:0] access_count
);

    localparam int WAIT_EFF = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX :
                              (WAIT_STATES < 0) ? 0 : WAIT_STATES;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_EFF);

    state_e      state;
    logic [3:0]  wait_cnt;
    logic [31:0] adr_q;
    logic [31:0] din_q;
    logic [3:0]  sel_q;
    logic        we_q;

    logic        in_window;
    logic        aligned;
    logic        retry_hit;
    term_e       term;

    logic [ADDR_WIDTH-1:0] arr_idx;
    logic                  arr_wr_en;
    logic [31:0]           arr_rdata;

    assign in_window = (adr_q[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign aligned   = (adr_q[1:0] == 2'b00);

`ifdef WB_SLAVE_RETRY_EN
    logic [15:0] rty_cnt;
    logic [15:0] rty_cnt_next;

    assign rty_cnt_next = rty_cnt + 16'd1;
    assign retry_hit    = (rty_cnt_next == 16'(RTY_PERIOD));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rty_cnt <= '0;
        end else if (state == ST_RESP && in_window && aligned) begin
            rty_cnt <= retry_hit ? '0 : rty_cnt_next;
        end
    end
`else
    logic unused_rty_period;

    // RTY_PERIOD only has meaning when the retry option is built in.
    assign unused_rty_period = (RTY_PERIOD != 0);
    assign retry_hit         = 1'b0;
    assign rty               = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        term = TERM_ACK;
        if (!in_window || !aligned) begin
            term = TERM_ERR;
        end else if (retry_hit) begin
            term = TERM_RTY;
        end
    end

    // In IDLE the array is pointed at the live bus address so read data is ready
    // by the RESP clock even with zero wait states.
    assign arr_idx   = (state == ST_IDLE) ? adr[ADDR_WIDTH+1:2] : adr_q[ADDR_WIDTH+1:2];
    assign arr_wr_en = (state == ST_RESP) && we_q && (term == TERM_ACK);

    wishbone_slave_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .wr_en (arr_wr_en),
        .idx   (arr_idx),
        .sel   (sel_q),
        .wdata (din_q),
        .rdata (arr_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            adr_q        <= '0;
            din_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            ack          <= 1'b0;
            err          <= 1'b0;
`ifdef WB_SLAVE_RETRY_EN
            rty          <= 1'b0;
`endif
            dout         <= '0;
            access_count <= '0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
`ifdef WB_SLAVE_RETRY_EN
            rty <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (cyc && stb) begin
                        adr_q    <= adr;
                        din_q    <= din;
                        sel_q    <= sel;
                        we_q     <= we;
                        wait_cnt <= WAIT_LOAD;
                        state    <= (WAIT_EFF > 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    // Dropping cyc abandons the access; a low stb alone is ignored.
                    if (!cyc) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt <= 4'd1) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_DONE;
                    case (term)
                        TERM_ACK: begin
                            ack          <= 1'b1;
                            access_count <= access_count + 16'd1;
                            if (!we_q) begin
                                dout <= arr_rdata & lane_mask(sel_q);
                            end
                        end
                        TERM_ERR: begin
                            err  <= 1'b1;
                            dout <= '0;
                        end
`ifdef WB_SLAVE_RETRY_EN
                        TERM_RTY: begin
                            rty <= 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                ST_DONE: begin
                    // Wait for the master to release the strobe before re-arming.
                    if (!stb || !cyc) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_slave_mem.sv
// Self-checking bench: two slaves (0 and 3 wait states) driven by directed and
// random classic-cycle accesses, checked against a behavioural memory model.
module tb_wishbone_slave_mem;

    localparam int AW         = 8;
    localparam int RTY_PERIOD = 4;
    localparam int WS0        = 0;
    localparam int WS1        = 3;

    localparam int T_NONE  = 0;
    localparam int T_ACK   = 1;
    localparam int T_ERR   = 2;
    localparam int T_RTY   = 3;
    localparam int T_MULTI = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr_b  [2];
    logic [31:0] din_b  [2];
    logic [31:0] dout_w [2];
    logic [3:0]  sel_b  [2];
    logic [15:0] cnt_w  [2];
    logic [1:0]  cyc_b, stb_b, we_b, ack_w, err_w, rty_w;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: word contents, known byte lanes, last dout, counters.
    logic [31:0] m_mem  [2][256];
    logic [3:0]  m_kn   [2][256];
    logic [31:0] m_dout [2];
    int          m_cnt  [2];
    int          m_rcnt [2];

    always #5 clk = ~clk;

    wishbone_slave_mem #(
        .ADDR_WIDTH(AW), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(WS0), .RTY_PERIOD(RTY_PERIOD)
    ) dut0 (
        .clk(clk), .rst(rst_n), .adr(adr_b[0]), .din(din_b[0]), .dout(dout_w[0]),
        .cyc(cyc_b[0]), .stb(stb_b[0]), .sel(sel_b[0]), .we(we_b[0]),
        .ack(ack_w[0]), .err(err_w[0]), .rty(rty_w[0]), .access_count(cnt_w[0])
    );

    wishbone_slave_mem #(
        .ADDR_WIDTH(AW), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(WS1), .RTY_PERIOD(RTY_PERIOD)
    ) dut1 (
        .clk(clk), .rst(rst_n), .adr(adr_b[1]), .din(din_b[1]), .dout(dout_w[1]),
        .cyc(cyc_b[1]), .stb(stb_b[1]), .sel(sel_b[1]), .we(we_b[1]),
        .ack(ack_w[1]), .err(err_w[1]), .rty(rty_w[1]), .access_count(cnt_w[1])
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    function automatic int term_seen(input int d);
        int k;
        k = int'(ack_w[d] === 1'b1) + int'(err_w[d] === 1'b1) + int'(rty_w[d] === 1'b1);
        if (k > 1) return T_MULTI;
        if (ack_w[d] === 1'b1) return T_ACK;
        if (err_w[d] === 1'b1) return T_ERR;
        if (rty_w[d] === 1'b1) return T_RTY;
        return T_NONE;
    endfunction

    // Applies one completed access to the model and returns the expected termination.
    function automatic int model_access(input int d, input logic [31:0] a, input logic [31:0] wd,
                                        input logic [3:0] s, input logic w);
        int          idx;
        logic [31:0] rd;
        if (a[31:AW+2] != '0 || a[1:0] != 2'b00) begin
            m_dout[d] = '0;
            return T_ERR;
        end
`ifdef WB_SLAVE_RETRY_EN
        m_rcnt[d] = m_rcnt[d] + 1;
        if (m_rcnt[d] == RTY_PERIOD) begin
            m_rcnt[d] = 0;
            return T_RTY;
        end
`endif
        m_cnt[d] = (m_cnt[d] + 1) % 65536;
        idx = int'(a[AW+1:2]);
        rd  = '0;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
                if (w) m_mem[d][idx][8*i +: 8] = wd[8*i +: 8];
                else   rd[8*i +: 8] = m_mem[d][idx][8*i +: 8];
            end
        end
        if (w) m_kn[d][idx] = m_kn[d][idx] | s;
        else   m_dout[d] = rd;
        return T_ACK;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_dout[d] = '0;
            m_cnt[d]  = 0;
            m_rcnt[d] = 0;
        end
    endtask

    // One classic-cycle access; called #1 after a rising edge with the slave idle.
    task automatic do_access(input int d, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] s, input logic w, input int hold,
                             output logic [31:0] rd, output int exp_t);
        int got_t, n, extra;
        exp_t = model_access(d, a, wd, s, w);
        adr_b[d] = a; din_b[d] = wd; sel_b[d] = s; we_b[d] = w;
        cyc_b[d] = 1'b1; stb_b[d] = 1'b1;
        @(posedge clk);
        got_t = T_NONE;
        n     = 0;
        while (got_t == T_NONE && n < 40) begin
            @(posedge clk); #1;
            n++;
            got_t = term_seen(d);
        end
        n_checks++;
        if (got_t !== exp_t) begin
            n_fail++;
            $display("FAIL term dut%0d adr=%h we=%0d: got %0d required %0d", d, a, w, got_t, exp_t);
        end
        n_checks++;
        if (n !== wait_of(d) + 1) begin
            n_fail++;
            $display("FAIL latency dut%0d adr=%h: got %0d required %0d", d, a, n, wait_of(d) + 1);
        end
        n_checks++;
        if (dout_w[d] !== m_dout[d]) begin
            n_fail++;
            $display("FAIL dout dut%0d adr=%h: got %h required %h", d, a, dout_w[d], m_dout[d]);
        end
        n_checks++;
        if (cnt_w[d] !== 16'(m_cnt[d])) begin
            n_fail++;
            $display("FAIL access_count dut%0d: got %0d required %0d", d, cnt_w[d], m_cnt[d]);
        end
        rd    = dout_w[d];
        extra = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (term_seen(d) != T_NONE) extra++;
        end
        cyc_b[d] = 1'b0; stb_b[d] = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (term_seen(d) != T_NONE || extra != 0) begin
            n_fail++;
            $display("FAIL one_pulse dut%0d adr=%h: extra terminations %0d, now %0d required 0",
                     d, a, extra, term_seen(d));
        end
    endtask

    // Repeats an access while the slave asks for a retry, as a real master would.
    task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input logic w, output logic [31:0] rd);
        int t, tries;
        tries = 0;
        do begin
            do_access(d, a, wd, s, w, 0, rd, t);
            tries++;
        end while (t == T_RTY && tries < 3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cyc_b[d] = 1'b0; stb_b[d] = 1'b0; we_b[d] = 1'b0;
            adr_b[d] = '0; din_b[d] = '0; sel_b[d] = '0;
        end
        model_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({ack_w[d], err_w[d], rty_w[d]} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_terms dut%0d: got %b required 000", d, {ack_w[d], err_w[d], rty_w[d]});
            end
            n_checks++;
            if (dout_w[d] !== 32'h0 || cnt_w[d] !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_regs dut%0d: dout %h count %0d required 0 and 0", d, dout_w[d], cnt_w[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        xfer(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, rd);
        xfer(0, 32'h10, 32'h0, 4'hF, 1'b0, rd);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL basic_read: got %h required deadbeef", rd);
        end
        n_checks++;
        if (cnt_w[0] !== 16'd2) begin
            n_fail++;
            $display("FAIL basic_count: got %0d required 2", cnt_w[0]);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        xfer(0, 32'h20, 32'h1122_3344, 4'hF, 1'b1, rd);
        xfer(0, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b1, rd);
        xfer(0, 32'h20, 32'h0, 4'hF, 1'b0, rd);
        n_checks++;
        if (rd !== 32'h11BB_33DD) begin
            n_fail++;
            $display("FAIL lanes_full: got %h required 11bb33dd", rd);
        end
        xfer(0, 32'h20, 32'h0, 4'b0011, 1'b0, rd);
        n_checks++;
        if (rd !== 32'h0000_33DD) begin
            n_fail++;
            $display("FAIL lanes_low: got %h required 000033dd", rd);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        xfer(1, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b1, rd);
        xfer(1, 32'h40, 32'h0, 4'hF, 1'b0, rd);
        n_checks++;
        if (rd !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL wait_read: got %h required cafef00d", rd);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int seen;
        adr_b[1] = 32'h40; din_b[1] = 32'h1234_5678; sel_b[1] = 4'hF; we_b[1] = 1'b1;
        cyc_b[1] = 1'b1; stb_b[1] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        cyc_b[1] = 1'b0; stb_b[1] = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (term_seen(1) != T_NONE) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_term: got %0d terminations required 0", seen);
        end
        n_checks++;
        if (cnt_w[1] !== 16'(m_cnt[1]) || dout_w[1] !== m_dout[1]) begin
            n_fail++;
            $display("FAIL abort_state: count %0d dout %h required %0d %h", cnt_w[1], dout_w[1], m_cnt[1], m_dout[1]);
        end
        // The aborted write must not have landed, and the slave must be idle again.
        xfer(1, 32'h40, 32'h0, 4'hF, 1'b0, rd);
        n_checks++;
        if (rd !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL abort_nowrite: got %h required cafef00d", rd);
        end
    endtask

    task automatic test_stb_drop_in_wait();
        int exp_t, got_t, n;
        exp_t = model_access(1, 32'h44, 32'h0BAD_F00D, 4'hF, 1'b1);
        adr_b[1] = 32'h44; din_b[1] = 32'h0BAD_F00D; sel_b[1] = 4'hF; we_b[1] = 1'b1;
        cyc_b[1] = 1'b1; stb_b[1] = 1'b1;
        @(posedge clk); #1;
        stb_b[1] = 1'b0;
        got_t = T_NONE;
        n     = 0;
        while (got_t == T_NONE && n < 40) begin
            @(posedge clk); #1;
            n++;
            got_t = term_seen(1);
        end
        n_checks++;
        if (got_t !== exp_t || n !== WS1 + 1) begin
            n_fail++;
            $display("FAIL stb_drop: term %0d after %0d clks required %0d after %0d", got_t, n, exp_t, WS1 + 1);
        end
        cyc_b[1] = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (term_seen(1) != T_NONE) begin
            n_fail++;
            $display("FAIL stb_drop_pulse: got %0d required 0", term_seen(1));
        end
    endtask

    task automatic test_error();
        logic [31:0] rd;
        int t;
        for (int d = 0; d < 2; d++) begin
            xfer(d, 32'h0, 32'h5A5A_0000 + 32'(d), 4'hF, 1'b1, rd);
            do_access(d, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 1'b1, 0, rd, t);
            do_access(d, 32'h0000_0002, 32'hFFFF_FFFF, 4'hF, 1'b1, 0, rd, t);
            do_access(d, 32'h8000_0000, 32'h0, 4'hF, 1'b0, 0, rd, t);
            xfer(d, 32'h0, 32'h0, 4'hF, 1'b0, rd);
            n_checks++;
            if (rd !== 32'h5A5A_0000 + 32'(d)) begin
                n_fail++;
                $display("FAIL err_nowrite dut%0d: got %h required %h", d, rd, 32'h5A5A_0000 + 32'(d));
            end
        end
    endtask

    task automatic test_retry();
        logic [31:0] rd;
        int t, n_rty, exp_rty, exp_cnt;
        test_reset();
        n_rty = 0;
        for (int i = 0; i < 8; i++) begin
            do_access(0, 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b1, 0, rd, t);
            if (t == T_RTY) n_rty++;
        end
`ifdef WB_SLAVE_RETRY_EN
        exp_rty = 2;
        exp_cnt = 6;
`else
        exp_rty = 0;
        exp_cnt = 8;
`endif
        n_checks++;
        if (n_rty != exp_rty || cnt_w[0] !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL retry: %0d retries count %0d required %0d and %0d", n_rty, cnt_w[0], exp_rty, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int t;
        for (int d = 0; d < 2; d++) begin
            do_access(d, 32'h60, 32'h600D_0000 + 32'(d), 4'hF, 1'b1, 5, rd, t);
            do_access(d, 32'h60, 32'h0, 4'hF, 1'b0, 0, rd, t);
            do_access(d, 32'h64, 32'h7777_7777, 4'b1000, 1'b1, 3, rd, t);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd;
        logic [3:0]  s;
        logic        w;
        int          t, idx, kind;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 150; i++) begin
                kind = $urandom_range(0, 99);
                idx  = $urandom_range(0, 255);
                a    = {22'h0, 8'(idx), 2'b00};
                if (kind < 8) begin
                    a = $urandom;
                    if (a[31:AW+2] == '0) a[20] = 1'b1;
                end else if (kind < 13) begin
                    a[1:0] = 2'($urandom_range(1, 3));
                end
                wd = $urandom;
                s  = 4'($urandom);
                w  = 1'($urandom);
                if (!w && (s & ~m_kn[d][idx]) != 4'h0) w = 1'b1;
                do_access(d, a, wd, s, w, $urandom_range(0, 2), rd, t);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd;
        xfer(1, 32'h80, 32'hAAAA_5555, 4'hF, 1'b1, rd);
        xfer(0, 32'h84, 32'h1357_9BDF, 4'hF, 1'b1, rd);
        // Reset while slave 1 waits on a write.
        adr_b[1] = 32'h80; din_b[1] = 32'hFFFF_0000; sel_b[1] = 4'hF; we_b[1] = 1'b1;
        cyc_b[1] = 1'b1; stb_b[1] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({ack_w[1], err_w[1], rty_w[1]} !== 3'b000 || cnt_w[0] !== 16'h0 || cnt_w[1] !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_wait: terms %b counts %0d %0d required 000 0 0",
                     {ack_w[1], err_w[1], rty_w[1]}, cnt_w[0], cnt_w[1]);
        end
        cyc_b[1] = 1'b0; stb_b[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 32'h80, 32'h0, 4'hF, 1'b0, rd);
        n_checks++;
        if (rd !== 32'hAAAA_5555) begin
            n_fail++;
            $display("FAIL reset_discard: got %h required aaaa5555", rd);
        end
        // Reset while slave 0 is presenting its termination.
        adr_b[0] = 32'h84; sel_b[0] = 4'hF; we_b[0] = 1'b0;
        cyc_b[0] = 1'b1; stb_b[0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        n_checks++;
        if (term_seen(0) != T_ACK && term_seen(0) != T_RTY) begin
            n_fail++;
            $display("FAIL reset_pre_term: got %0d required ack or rty", term_seen(0));
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({ack_w[0], err_w[0], rty_w[0]} !== 3'b000 || dout_w[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_resp: terms %b dout %h required 000 0", {ack_w[0], err_w[0], rty_w[0]}, dout_w[0]);
        end
        cyc_b[0] = 1'b0; stb_b[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) begin
                m_mem[d][i] = '0;
                m_kn[d][i]  = 4'h0;
            end
        end
        test_reset();
        test_basic();
        test_byte_lanes();
        test_wait_states();
        test_abort();
        test_stb_drop_in_wait();
        test_error();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        test_retry();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
